ysyx_220053_dmem_resp: RTL

- Data-memory responder (slave) for the EXU load/store path: the other end of the Mem access interface that the execute stage drives.
- Accepts one load/store request over a valid/ready handshake and performs the access on an internal 64-bit-wide SRAM array.
- Returns the read data or a write acknowledgement after a programmable latency.
- Replaces the zero-latency DPI memory so the pipeline can be exercised against realistic wait states.

---
 rtl/ysyx_220053_mem_pkg.sv | 25 ++
 rtl/ysyx_220053_mem_align.sv | 48 ++++
 rtl/ysyx_220053_dmem_resp.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ysyx_220053_mem_pkg.sv
// Shared definitions for the data-memory path: MemOp encodings used by both the
// EXU and the responder, plus the responder FSM state encoding.
package ysyx_220053_mem_pkg;

    localparam logic [2:0] MEMOP_B    = 3'b000;
    localparam logic [2:0] MEMOP_H    = 3'b001;
    localparam logic [2:0] MEMOP_W    = 3'b010;
    localparam logic [2:0] MEMOP_D    = 3'b011;
    localparam logic [2:0] MEMOP_BU   = 3'b100;
    localparam logic [2:0] MEMOP_HU   = 3'b101;
    localparam logic [2:0] MEMOP_WU   = 3'b110;
    localparam logic [2:0] MEMOP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // log2 of the access width in bytes; bit 2 only selects extension on loads
    function automatic logic [1:0] memop_size(input logic [2:0] op);
        return op[1:0];
    endfunction

endpackage

// File: rtl/ysyx_220053_mem_align.sv
// Lane alignment for one 64-bit row: load extraction/extension, store byte mask
// and lane-shifted store data, and natural-alignment check.
module ysyx_220053_mem_align
    import ysyx_220053_mem_pkg::*;
(
    input  logic [2:0]  memop,
    input  logic [2:0]  lane,
    input  logic [63:0] row,
    input  logic [63:0] wdata,
    output logic [63:0] ldata,
    output logic [7:0]  bmask,
    output logic [63:0] wdata_sh,
    output logic        misalign
);

    logic [63:0] sh;
    logic [7:0]  base_mask;

    assign sh       = row >> {lane, 3'b000};
    assign wdata_sh = wdata << {lane, 3'b000};
    assign bmask    = base_mask << lane;

    always_comb begin
        ldata = '0;
        case (memop)
            MEMOP_B:    ldata = {{56{sh[7]}}, sh[7:0]};
            MEMOP_H:    ldata = {{48{sh[15]}}, sh[15:0]};
            MEMOP_W:    ldata = {{32{sh[31]}}, sh[31:0]};
            MEMOP_D:    ldata = sh;
            MEMOP_BU:   ldata = {56'b0, sh[7:0]};
            MEMOP_HU:   ldata = {48'b0, sh[15:0]};
            MEMOP_WU:   ldata = {32'b0, sh[31:0]};
            MEMOP_RSVD: ldata = '0;
        endcase
    end

    always_comb begin
        base_mask = 8'h01;
        misalign  = 1'b0;
        case (memop_size(memop))
            2'd0: begin base_mask = 8'h01; misalign = 1'b0;        end
            2'd1: begin base_mask = 8'h03; misalign = lane[0];     end
            2'd2: begin base_mask = 8'h0F; misalign = |lane[1:0];  end
            2'd3: begin base_mask = 8'hFF; misalign = |lane;       end
        endcase
    end

endmodule

// File: rtl/ysyx_220053_dmem_resp.sv
// Data-memory responder: one outstanding load/store, serviced from an internal
// 64-bit-wide array after a programmable number of wait cycles.
module ysyx_220053_dmem_resp
    import ysyx_220053_mem_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LAT        = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_memop,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        do_access;

    logic        cap_wen, cur_wen;
    logic [63:0] cap_addr, cur_addr, cap_wdata, cur_wdata;
    logic [2:0]  cap_memop, cur_memop;

    logic [60:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  oor, misalign, err;
    logic [63:0]           row, ldata, wdata_sh, wmask;
    logic [7:0]            bmask;
    logic [63:0]           mem [DEPTH];

    // With LAT == 1 the access happens on the accept edge itself, so it has to
    // see the live request instead of the capture registers.
    assign cur_wen   = (state == ST_IDLE) ? req_wen   : cap_wen;
    assign cur_addr  = (state == ST_IDLE) ? req_addr  : cap_addr;
    assign cur_memop = (state == ST_IDLE) ? req_memop : cap_memop;
    assign cur_wdata = (state == ST_IDLE) ? req_wdata : cap_wdata;

    assign off = cur_addr[63:3] - ADDR_BASE[63:3];
    assign idx = off[DEPTH_LOG2-1:0];
    assign oor = (cur_addr < ADDR_BASE) | (|off[60:DEPTH_LOG2]);
    assign row = mem[idx];
    assign err = misalign | oor | (~cur_wen & (cur_memop == MEMOP_RSVD));

    ysyx_220053_mem_align u_align (
        .memop    (cur_memop),
        .lane     (cur_addr[2:0]),
        .row      (row),
        .wdata    (cur_wdata),
        .ldata    (ldata),
        .bmask    (bmask),
        .wdata_sh (wdata_sh),
        .misalign (misalign)
    );

    for (genvar i = 0; i < 8; i++) begin : g_wmask
        assign wmask[8*i +: 8] = {8{bmask[i]}};
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LAT == 1) begin
                        state_nxt = ST_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                // access on the edge that brings the counter to 0, so RESP is
                // reached LAT-1 edges after accept, same as the LAT == 1 path
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = ST_RESP;
                    do_access = 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_wen   <= 1'b0;
            cap_addr  <= '0;
            cap_memop <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_IDLE && req_valid) begin
                cap_wen   <= req_wen;
                cap_addr  <= req_addr;
                cap_memop <= req_memop;
                cap_wdata <= req_wdata;
            end
            if (do_access) begin
                rsp_err   <= err;
                rsp_rdata <= (err | cur_wen) ? '0 : ldata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_access & cur_wen & ~err)
            mem[idx] <= (row & ~wmask) | (wdata_sh & wmask);
    end

endmodule
